// File: rtl/tree_node_loader.sv
// tree_node_loader: accepts packed node words and replays each as four per-field writes to the tree evaluator.
// Optional build macro TREE_LOADER_ORDER_CHECK_EN adds the sticky err_order output.
module tree_node_loader #(
   parameter int W_ADDR   = 10,
   parameter int W_DATA   = 12,
   parameter int W_ACTION = 3,
   parameter int W_REWARD = 12,
   parameter int W_WEIGHT = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              mem_par,
   output logic              mem_act,
   output logic              mem_rew,
   output logic              mem_weight,
   output logic [W_ADDR-1:0] mem_addr,
   output logic [W_DATA-1:0] mem_data,
   output logic              conf_nodes,
   output logic [W_ADDR-1:0] conf_data,
   output logic              load_done,
   output logic              busy,
   output logic              err_ovf,
   input  logic              err_clr
`ifdef TREE_LOADER_ORDER_CHECK_EN
   ,
   output logic              err_order
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WR_PAR = 3'd1;
   localparam logic [2:0] S_WR_ACT = 3'd2;
   localparam logic [2:0] S_WR_REW = 3'd3;
   localparam logic [2:0] S_WR_WGT = 3'd4;
   localparam logic [2:0] S_CONF   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_DRAIN  = 3'd7;

   localparam int OFS_REW = W_WEIGHT;
   localparam int OFS_ACT = OFS_REW + W_REWARD;
   localparam int OFS_PAR = OFS_ACT + W_ACTION;

   // Highest usable node address; a frame still running here is forced to end.
   localparam logic [W_ADDR-1:0] LAST_ADDR = {{(W_ADDR-1){1'b1}}, 1'b0};

   logic [2:0]        state_reg, state_next;
   logic [W_ADDR-1:0] count_reg;
   logic [31:0]       hold_reg;
   logic              last_reg;
   logic              drain_reg;
   logic              err_ovf_reg;
   logic              accept;
   logic              idle_accept;
   logic              at_limit;
   logic [3:0]        field_strobe;
   logic [W_DATA-1:0] field_data;

   assign s_ready     = ((state_reg == S_IDLE) || (state_reg == S_DRAIN)) && !rst;
   assign accept      = s_valid && s_ready;
   assign idle_accept = accept && (state_reg == S_IDLE);
   assign at_limit    = (count_reg == LAST_ADDR);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (idle_accept) state_next = S_WR_PAR;
         S_WR_PAR: state_next = S_WR_ACT;
         S_WR_ACT: state_next = S_WR_REW;
         S_WR_REW: state_next = S_WR_WGT;
         S_WR_WGT: state_next = last_reg ? S_CONF : S_IDLE;
         S_CONF:   state_next = S_DONE;
         S_DONE:   state_next = drain_reg ? S_DRAIN : S_IDLE;
         S_DRAIN:  if (accept && s_last) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         count_reg   <= '0;
         hold_reg    <= '0;
         last_reg    <= 1'b0;
         drain_reg   <= 1'b0;
         err_ovf_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (idle_accept) begin
            hold_reg  <= s_data;
            last_reg  <= s_last || at_limit;
            drain_reg <= !s_last && at_limit;
         end
         if ((state_reg == S_WR_WGT) && !last_reg)
            count_reg <= count_reg + W_ADDR'(1);
         else if (state_reg == S_DONE)
            count_reg <= '0;
         // A new overflow outranks a simultaneous clear.
         if (idle_accept && !s_last && at_limit)
            err_ovf_reg <= 1'b1;
         else if (err_clr)
            err_ovf_reg <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
      assign field_strobe[gi] = (state_reg == (S_WR_PAR + 3'(gi)));
   end

   assign {mem_weight, mem_rew, mem_act, mem_par} = field_strobe;

   always_comb begin
      field_data = '0;
      case (state_reg)
         S_WR_PAR: field_data = W_DATA'(hold_reg[OFS_PAR +: W_ADDR]);
         S_WR_ACT: field_data = W_DATA'(hold_reg[OFS_ACT +: W_ACTION]);
         S_WR_REW: field_data = W_DATA'(hold_reg[OFS_REW +: W_REWARD]);
         S_WR_WGT: field_data = W_DATA'(hold_reg[0 +: W_WEIGHT]);
         default:  field_data = '0;
      endcase
   end

   assign mem_addr   = count_reg;
   assign mem_data   = field_data;
   assign conf_nodes = (state_reg == S_CONF);
   assign conf_data  = conf_nodes ? (count_reg + W_ADDR'(1)) : '0;
   assign load_done  = (state_reg == S_DONE);
   assign busy       = (state_reg != S_IDLE);
   assign err_ovf    = err_ovf_reg;

`ifdef TREE_LOADER_ORDER_CHECK_EN
   logic err_order_reg;

   // Root (address 0) is exempt; every other node must point to an earlier one.
   always_ff @(posedge clk) begin
      if (rst)
         err_order_reg <= 1'b0;
      else if (idle_accept && (count_reg != '0) && (s_data[OFS_PAR +: W_ADDR] >= count_reg))
         err_order_reg <= 1'b1;
      else if (err_clr)
         err_order_reg <= 1'b0;
   end

   assign err_order = err_order_reg;
`endif

endmodule

// File: tb/tb_tree_node_loader.sv
// Randomised bench for tree_node_loader against an event-list reference model.
// Build with TREE_LOADER_ORDER_CHECK_EN defined to also exercise err_order.
module tb_tree_node_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        mem_par, mem_act, mem_rew, mem_weight;
   logic [9:0]  mem_addr;
   logic [11:0] mem_data;
   logic        conf_nodes;
   logic [9:0]  conf_data;
   logic        load_done;
   logic        busy;
   logic        err_ovf;
   logic        err_clr = 1'b0;
`ifdef TREE_LOADER_ORDER_CHECK_EN
   logic        err_order;
`endif

   tree_node_loader dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .mem_par    (mem_par),
      .mem_act    (mem_act),
      .mem_rew    (mem_rew),
      .mem_weight (mem_weight),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .conf_nodes (conf_nodes),
      .conf_data  (conf_data),
      .load_done  (load_done),
      .busy       (busy),
      .err_ovf    (err_ovf),
      .err_clr    (err_clr)
`ifdef TREE_LOADER_ORDER_CHECK_EN
      ,
      .err_order  (err_order)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event kinds: 0 parent, 1 action, 2 reward, 3 weight, 4 conf, 5 done
   typedef struct {
      int kind;
      int addr;
      int data;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  model_count = 0;
   bit  model_drain = 1'b0;
   bit  exp_ovf = 1'b0;
   bit  exp_order = 1'b0;
   int  conf_cyc = -100;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: a frame of N nodes produces 4 writes per node at addresses 0..N-1,
   // then a node-count config write and a done pulse; a frame longer than 1023
   // nodes is cut at address 1022 and the rest of it is swallowed.
   function automatic bit model_accept(input logic [31:0] w, input bit last);
      int addr;
      int par;
      bit eff_last;
      if (model_drain) begin
         if (last) model_drain = 1'b0;
         return 1'b1;
      end
      addr = model_count;
      par  = int'(w[31:22]);
      eff_last = last;
      if (addr == 1022 && !last) begin
         exp_ovf     = 1'b1;
         eff_last    = 1'b1;
         model_drain = 1'b1;
      end
      if (addr != 0 && par >= addr) exp_order = 1'b1;
      exp_q.push_back('{0, addr, par});
      exp_q.push_back('{1, addr, int'(w[21:19])});
      exp_q.push_back('{2, addr, int'(w[18:7])});
      exp_q.push_back('{3, addr, int'(w[6:0])});
      if (eff_last) begin
         exp_q.push_back('{4, 0, addr + 1});
         exp_q.push_back('{5, 0, 0});
         model_count = 0;
      end else begin
         model_count = addr + 1;
      end
      return 1'b0;
   endfunction

   // Output monitor: every strobe/conf/done cycle must match the next expected event.
   always @(negedge clk) begin
      int  cnt;
      int  k;
      ev_t e;
      if (!rst) begin
         cnt = int'(mem_par) + int'(mem_act) + int'(mem_rew) + int'(mem_weight)
             + int'(conf_nodes) + int'(load_done);
         if (cnt != 0) begin
            check("onehot", cnt, 1);
            k = mem_par ? 0 : mem_act ? 1 : mem_rew ? 2 : mem_weight ? 3 : conf_nodes ? 4 : 5;
            if (exp_q.size() == 0) begin
               check("unexpected_event", k, 7);
            end else begin
               e = exp_q.pop_front();
               check("ev_kind", k, e.kind);
               if (k < 4) begin
                  check("mem_addr", mem_addr, e.addr);
                  check("mem_data", mem_data, e.data);
               end else if (k == 4) begin
                  check("conf_data", conf_data, e.data);
                  conf_cyc = cyc;
               end else begin
                  check("done_after_conf", cyc - conf_cyc, 1);
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [31:0] w, input bit last, input int max_gap,
                            output int acc_cyc);
      int gap;
      bit ok;
      bit drained;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data  = w;
      s_last  = last;
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
         #1;
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("ready_timeout", 0, 1);
         s_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk);
      acc_cyc = cyc;
      drained = model_accept(w, last);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("first_strobe", mem_par, !drained);
      if (drained && !last) check("drain_busy", busy, 1);
   endtask

   task automatic send_frame(input int n, input int max_gap);
      int a;
      for (int i = 0; i < n; i++) send_beat($urandom, (i == n - 1), max_gap, a);
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 100 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
      check("events_done", exp_q.size(), 0);
      check("busy_low", busy, 0);
      check("err_ovf", err_ovf, exp_ovf);
`ifdef TREE_LOADER_ORDER_CHECK_EN
      check("err_order", err_order, exp_order);
`endif
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_ovf = 1'b0;
      exp_order = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {s_ready, mem_par, mem_act, mem_rew, mem_weight, conf_nodes, load_done,
                  busy, err_ovf}, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_data"}, mem_data, 0);
      check({tag, "_conf"}, conf_data, 0);
   endtask

   initial begin
      int a0, a1, a2, n;
      logic [31:0] w;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
`ifdef TREE_LOADER_ORDER_CHECK_EN
      check("reset_order", err_order, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Directed single node frame
      send_beat(32'h00400A85, 1'b1, 0, a0);
      wait_idle();

      // Three nodes with s_valid held high: accepts 5 cycles apart
      send_beat($urandom, 1'b0, 0, a0);
      send_beat($urandom, 1'b0, 0, a1);
      send_beat($urandom, 1'b1, 0, a2);
      check("spacing01", a1 - a0, 5);
      check("spacing12", a2 - a1, 5);
      wait_idle();

      // Random frames with random idle gaps
      for (int f = 0; f < 8; f++) begin
         n = $urandom_range(6, 1);
         send_frame(n, 7);
         wait_idle();
      end
      pulse_clr();

      // Overflow: 1025 beats, last flagged only on the final beat
      for (int i = 0; i < 1025; i++) begin
         send_beat($urandom, (i == 1024), 1, a0);
         if (i == 1021) check("ovf_before_limit", err_ovf, 0);
         if (i == 1022) check("ovf_at_limit", err_ovf, exp_ovf);
      end
      wait_idle();
      pulse_clr();
      check("ovf_cleared", err_ovf, 0);

      // Reset in the middle of node 4's reward write
      for (int i = 0; i < 4; i++) send_beat($urandom, 1'b0, 0, a0);
      send_beat($urandom, 1'b0, 0, a0);
      @(negedge clk);
      @(negedge clk);
      check("rew_before_rst", mem_rew, 1);
      check("addr_before_rst", mem_addr, 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midframe_rst");
      exp_q.delete();
      model_count = 0;
      model_drain = 1'b0;
      exp_ovf = 1'b0;
      exp_order = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send_frame(2, 3);
      wait_idle();

`ifdef TREE_LOADER_ORDER_CHECK_EN
      // Parent-order check: node 2 pointing at itself
      pulse_clr();
      w = $urandom;
      w[31:22] = 10'd0;
      send_beat(w, 1'b0, 0, a0);
      w = $urandom;
      w[31:22] = 10'd0;
      send_beat(w, 1'b0, 0, a0);
      check("order_clean", err_order, 0);
      w = $urandom;
      w[31:22] = 10'd2;
      send_beat(w, 1'b1, 0, a0);
      check("order_set", err_order, 1);
      wait_idle();
      pulse_clr();
      check("order_cleared", err_order, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
